// File: rtl/cfa_pkg.sv
// Shared encodings for the CFA colour-difference equation blocks.
// OUT_W = PIX_W + 3 is exposed via out_w() so every block derives it the same way.
package cfa_pkg;

    typedef enum logic [1:0] {
        MODE_FULL  = 2'd0,
        MODE_ANTI  = 2'd1,
        MODE_MAIN  = 2'd2,
        MODE_ADAPT = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        DIR_FULL = 2'd0,
        DIR_ANTI = 2'd1,
        DIR_MAIN = 2'd2
    } dir_e;

    localparam logic [1:0] SH_FULL = 2'd2;
    localparam logic [1:0] SH_DIAG = 2'd1;

    function automatic int out_w(input int pix_w);
        return pix_w + 3;
    endfunction

endpackage

// File: rtl/cfa_div_pow2.sv
// Combinational signed divide by 2^sh_i (sh_i in 0..2).
// ROUND_EN=0 truncates toward zero, ROUND_EN=1 rounds half away from zero.
module cfa_div_pow2 #(
    parameter int W        = 15,
    parameter bit ROUND_EN = 1'b0
) (
    input  logic signed [W-1:0] num_i,
    input  logic        [1:0]   sh_i,
    output logic signed [W-1:0] q_o
);

    logic [W-1:0] pow_w;
    assign pow_w = W'(1) << sh_i;

    generate
        if (ROUND_EN) begin : g_round
            logic [W-1:0] mag;
            logic [W-1:0] rnd;
            assign mag = num_i[W-1] ? W'(-num_i) : W'(num_i);
            assign rnd = (mag + (pow_w >> 1)) >> sh_i;
            assign q_o = num_i[W-1] ? -$signed(rnd) : $signed(rnd);
        end else begin : g_trunc
            // Bias negatives by 2^sh-1 so the arithmetic shift truncates toward zero.
            logic        [W-1:0] bias;
            logic signed [W-1:0] biased;
            assign bias   = num_i[W-1] ? (pow_w - W'(1)) : '0;
            assign biased = num_i + $signed(bias);
            assign q_o    = biased >>> sh_i;
        end
    endgenerate

endmodule

// File: rtl/cfa_diag_diff_pipe.sv
// Three-stage diagonal G-RB colour-difference estimator with global-stall flow control.
// Define CFA_DIFF_ROUND_EN to round half away from zero instead of truncating.
module cfa_diag_diff_pipe
    import cfa_pkg::*;
#(
    parameter  int PIX_W = 12,
    parameter  int CNT_W = 16,
    localparam int OUT_W = out_w(PIX_W)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              mode,
    input  logic [PIX_W-1:0]        G_m1_m1,
    input  logic [PIX_W-1:0]        G_m1_p1,
    input  logic [PIX_W-1:0]        G_p1_m1,
    input  logic [PIX_W-1:0]        G_p1_p1,
    input  logic [PIX_W-1:0]        RB_m1_m1,
    input  logic [PIX_W-1:0]        RB_m1_p1,
    input  logic [PIX_W-1:0]        RB_p1_m1,
    input  logic [PIX_W-1:0]        RB_p1_p1,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out,
    output logic [1:0]              out_dir,
    output logic [CNT_W-1:0]        out_cnt
);

`ifdef CFA_DIFF_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    localparam int DW = PIX_W + 2;

    function automatic logic [PIX_W-1:0] absdiff(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    logic adv;
    logic v1_q, v2_q, v3_q;

    // Whole pipe freezes together; bubbles are not squeezed out.
    assign adv      = out_ready || !v3_q;
    assign in_ready = adv;

    // S1: diagonal sums and gradients
    logic [PIX_W:0]         g_a, g_m, rb_a, rb_m;
    logic signed [DW-1:0]   dga_d, dgm_d, dga_q, dgm_q;
    logic [PIX_W-1:0]       grada_d, gradm_d, grada_q, gradm_q;
    mode_e                  mode1_q;

    assign g_a     = {1'b0, G_m1_p1}  + {1'b0, G_p1_m1};
    assign g_m     = {1'b0, G_m1_m1}  + {1'b0, G_p1_p1};
    assign rb_a    = {1'b0, RB_m1_p1} + {1'b0, RB_p1_m1};
    assign rb_m    = {1'b0, RB_m1_m1} + {1'b0, RB_p1_p1};
    assign dga_d   = $signed({1'b0, g_a}) - $signed({1'b0, rb_a});
    assign dgm_d   = $signed({1'b0, g_m}) - $signed({1'b0, rb_m});
    assign grada_d = absdiff(RB_m1_p1, RB_p1_m1);
    assign gradm_d = absdiff(RB_m1_m1, RB_p1_p1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            mode1_q <= MODE_FULL;
            dga_q   <= '0;
            dgm_q   <= '0;
            grada_q <= '0;
            gradm_q <= '0;
        end else if (adv) begin
            v1_q    <= in_valid;
            mode1_q <= mode_e'(mode);
            dga_q   <= dga_d;
            dgm_q   <= dgm_d;
            grada_q <= grada_d;
            gradm_q <= gradm_d;
        end
    end

    // S2: path selection
    mode_e                   sel;
    logic signed [OUT_W-1:0] num_d, num2_q;
    logic [1:0]              sh_d, sh2_q;
    dir_e                    dir_d, dir2_q;

    always_comb begin
        sel = mode1_q;
        if (mode1_q == MODE_ADAPT) begin
            if (grada_q < gradm_q)      sel = MODE_ANTI;
            else if (gradm_q < grada_q) sel = MODE_MAIN;
            else                        sel = MODE_FULL;
        end
        num_d = OUT_W'(dga_q) + OUT_W'(dgm_q);
        sh_d  = SH_FULL;
        dir_d = DIR_FULL;
        case (sel)
            MODE_ANTI: begin
                num_d = OUT_W'(dga_q);
                sh_d  = SH_DIAG;
                dir_d = DIR_ANTI;
            end
            MODE_MAIN: begin
                num_d = OUT_W'(dgm_q);
                sh_d  = SH_DIAG;
                dir_d = DIR_MAIN;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q   <= 1'b0;
            num2_q <= '0;
            sh2_q  <= SH_FULL;
            dir2_q <= DIR_FULL;
        end else if (adv) begin
            v2_q   <= v1_q;
            num2_q <= num_d;
            sh2_q  <= sh_d;
            dir2_q <= dir_d;
        end
    end

    // S3: scale and count accepted results
    logic signed [OUT_W-1:0] q_d, out_q;
    dir_e                    dir3_q;
    logic [CNT_W-1:0]        cnt_q;

    cfa_div_pow2 #(
        .W        (OUT_W),
        .ROUND_EN (ROUND_EN)
    ) u_div (
        .num_i (num2_q),
        .sh_i  (sh2_q),
        .q_o   (q_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3_q   <= 1'b0;
            out_q  <= '0;
            dir3_q <= DIR_FULL;
        end else if (adv) begin
            v3_q   <= v2_q;
            out_q  <= q_d;
            dir3_q <= dir2_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    cnt_q <= '0;
        else if (v3_q && out_ready) cnt_q <= cnt_q + CNT_W'(1);
    end

    assign out_valid = v3_q;
    assign out       = out_q;
    assign out_dir   = dir3_q;
    assign out_cnt   = cnt_q;

endmodule

// File: tb/tb_cfa_diag_diff_pipe.sv
// Directed self-checking bench for cfa_diag_diff_pipe (PIX_W=12, OUT_W=15).
// Expected values are hand-computed; rounded variants apply when CFA_DIFF_ROUND_EN is defined.
module tb_cfa_diag_diff_pipe;

`ifdef CFA_DIFF_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [1:0] mode = 2'd0;
    logic [11:0] g_mm = '0, g_mp = '0, g_pm = '0, g_pp = '0;
    logic [11:0] r_mm = '0, r_mp = '0, r_pm = '0, r_pp = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic signed [14:0] out;
    logic [1:0] out_dir;
    logic [15:0] out_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cfa_diag_diff_pipe #(.PIX_W(12), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .G_m1_m1(g_mm), .G_m1_p1(g_mp), .G_p1_m1(g_pm), .G_p1_p1(g_pp),
        .RB_m1_m1(r_mm), .RB_m1_p1(r_mp), .RB_p1_m1(r_pm), .RB_p1_p1(r_pp),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_dir(out_dir), .out_cnt(out_cnt)
    );

    task automatic set_in(input int m, input int gmm, input int gmp, input int gpm, input int gpp,
                          input int rmm, input int rmp, input int rpm, input int rpp);
        mode = 2'(m);
        g_mm = 12'(gmm); g_mp = 12'(gmp); g_pm = 12'(gpm); g_pp = 12'(gpp);
        r_mm = 12'(rmm); r_mp = 12'(rmp); r_pm = 12'(rpm); r_pp = 12'(rpp);
    endtask

    // Push one sample into an empty pipe; capture outputs one cycle early and at the 3-cycle point.
    task automatic run_one(input int m, input int gmm, input int gmp, input int gpm, input int gpp,
                           input int rmm, input int rmp, input int rpm, input int rpp,
                           output logic signed [14:0] o, output logic [1:0] d,
                           output logic early, output logic vld, output logic [15:0] c);
        set_in(m, gmm, gmp, gpm, gpp, rmm, rmp, rpm, rpp);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        early = out_valid;
        @(posedge clk); #1;
        vld = out_valid; o = out; d = out_dir; c = out_cnt;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (out_valid !== 1'b0 || out !== 15'sd0 || out_dir !== 2'd0 || out_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_state valid=%b out=%0d dir=%0d cnt=%0d want 0/0/0/0", out_valid, out, out_dir, out_cnt);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b want 1", in_ready);
        end
    endtask

    task automatic test_mode0();
        logic signed [14:0] o; logic [1:0] d; logic e, v; logic [15:0] c;
        run_one(0, 100, 100, 100, 100, 40, 40, 40, 40, o, d, e, v, c);
        checks++;
        if (e !== 1'b0 || v !== 1'b1) begin
            errors++;
            $display("FAIL m0_latency early=%b at3=%b want 0 1", e, v);
        end
        checks++;
        if (o !== 15'sd60 || d !== 2'd0) begin
            errors++;
            $display("FAIL m0_value out=%0d dir=%0d want 60 0", o, d);
        end
        checks++;
        if (out_cnt !== 16'd1) begin
            errors++;
            $display("FAIL m0_cnt got=%0d want 1", out_cnt);
        end
    endtask

    // {mode, Gmm, Gmp, Gpm, Gpp, RBmm, RBmp, RBpm, RBpp, trunc, round, dir}
    task automatic test_rounding();
        int tv [5][12] = '{
            '{0, 0, 0, 0, 0, 1, 1, 1, 2, -1, -1, 0},
            '{0, 0, 0, 0, 0, 1, 1, 2, 2, -1, -2, 0},
            '{1, 0, 0, 0, 0, 0, 1, 2, 0, -1, -2, 1},
            '{2, 7, 0, 0, 0, 0, 0, 0, 0,  3,  4, 2},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0}
        };
        logic signed [14:0] o, ex; logic [1:0] d; logic e, v; logic [15:0] c;
        for (int i = 0; i < 5; i++) begin
            run_one(tv[i][0], tv[i][1], tv[i][2], tv[i][3], tv[i][4],
                    tv[i][5], tv[i][6], tv[i][7], tv[i][8], o, d, e, v, c);
            ex = RND ? 15'(tv[i][10]) : 15'(tv[i][9]);
            checks++;
            if (v !== 1'b1 || o !== ex || d !== 2'(tv[i][11])) begin
                errors++;
                $display("FAIL round[%0d] vld=%b out=%0d dir=%0d want 1 %0d %0d", i, v, o, d, ex, tv[i][11]);
            end
        end
    endtask

    task automatic test_adaptive();
        int tv [3][12] = '{
            '{3,  0, 50, 50,  0, 0, 10,  12, 500, 39, 39, 1},
            '{3,  0, 50, 50,  0, 5, 10,  12,   7, 16, 17, 0},
            '{3, 20,  0,  0, 20, 3,  0, 100,   4, 16, 17, 2}
        };
        logic signed [14:0] o, ex; logic [1:0] d; logic e, v; logic [15:0] c;
        for (int i = 0; i < 3; i++) begin
            run_one(tv[i][0], tv[i][1], tv[i][2], tv[i][3], tv[i][4],
                    tv[i][5], tv[i][6], tv[i][7], tv[i][8], o, d, e, v, c);
            ex = RND ? 15'(tv[i][10]) : 15'(tv[i][9]);
            checks++;
            if (v !== 1'b1 || o !== ex || d !== 2'(tv[i][11])) begin
                errors++;
                $display("FAIL adapt[%0d] vld=%b out=%0d dir=%0d want 1 %0d %0d", i, v, o, d, ex, tv[i][11]);
            end
        end
    endtask

    task automatic test_extremes();
        int tv [3][11] = '{
            '{0, 4095, 4095, 4095, 4095,    0,    0,    0,    0,  4095, 0},
            '{0,    0,    0,    0,    0, 4095, 4095, 4095, 4095, -4095, 0},
            '{1,    0, 4095, 4095,    0,    0,    0,    0,    0,  4095, 1}
        };
        logic signed [14:0] o, ex; logic [1:0] d; logic e, v; logic [15:0] c;
        for (int i = 0; i < 3; i++) begin
            run_one(tv[i][0], tv[i][1], tv[i][2], tv[i][3], tv[i][4],
                    tv[i][5], tv[i][6], tv[i][7], tv[i][8], o, d, e, v, c);
            ex = 15'(tv[i][9]);
            checks++;
            if (v !== 1'b1 || o !== ex || d !== 2'(tv[i][10])) begin
                errors++;
                $display("FAIL extreme[%0d] vld=%b out=%h dir=%0d want 1 %h %0d", i, v, o, d, ex, tv[i][10]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic signed [14:0] rx[$];
        logic signed [14:0] hold = '0;
        logic [15:0] cnt0;
        int sent = 0, got = 0, stall_bad = 0, stall_seen = 0;
        cnt0 = out_cnt;
        for (int c = 0; c < 40 && got < 6; c++) begin
            out_ready = !(c >= 4 && c < 8);
            in_valid  = (sent < 6);
            set_in(0, 10*(sent+1), 10*(sent+1), 10*(sent+1), 10*(sent+1), 0, 0, 0, 0);
            #3;
            if (c == 4) hold = out;
            if (!out_ready) begin
                stall_seen++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || out !== hold) stall_bad++;
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                rx.push_back(out);
                got++;
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != 6) begin
            errors++;
            $display("FAIL bp_count received=%0d want 6", got);
        end
        for (int k = 0; k < rx.size() && k < 6; k++) begin
            checks++;
            if (rx[k] !== 15'(10*(k+1))) begin
                errors++;
                $display("FAIL bp_order[%0d] out=%0d want %0d", k, rx[k], 10*(k+1));
            end
        end
        checks++;
        if (stall_seen != 4 || stall_bad != 0) begin
            errors++;
            $display("FAIL bp_stall cycles=%0d bad=%0d want 4 0", stall_seen, stall_bad);
        end
        checks++;
        if (out_cnt !== 16'(cnt0 + 16'd6)) begin
            errors++;
            $display("FAIL bp_cnt got=%0d want %0d", out_cnt, 16'(cnt0 + 16'd6));
        end
    endtask

    task automatic test_reset_midstream();
        logic signed [14:0] o; logic [1:0] d; logic e, v; logic [15:0] c;
        int leak = 0;
        for (int k = 0; k < 3; k++) begin
            set_in(0, 200+k, 200+k, 200+k, 200+k, 0, 0, 0, 0);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_full valid=%b want 1", out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_cnt !== 16'd0) begin
            errors++;
            $display("FAIL mid_rst valid=%b cnt=%0d want 0 0", out_valid, out_cnt);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) leak++;
        end
        checks++;
        if (leak != 0) begin
            errors++;
            $display("FAIL mid_leak stray_valid_cycles=%0d want 0", leak);
        end
        run_one(0, 100, 100, 100, 100, 40, 40, 40, 40, o, d, e, v, c);
        checks++;
        if (e !== 1'b0 || v !== 1'b1 || o !== 15'sd60 || c !== 16'd0) begin
            errors++;
            $display("FAIL mid_first early=%b vld=%b out=%0d cnt=%0d want 0 1 60 0", e, v, o, c);
        end
        checks++;
        if (out_cnt !== 16'd1) begin
            errors++;
            $display("FAIL mid_cnt got=%0d want 1", out_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_rounding();
        test_adaptive();
        test_extremes();
        test_back_to_back();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
